// File: rtl/dmem_access_ctrl_if.sv
// Request/response channel between the execute stage and the data-memory sequencer.
// The master side issues requests and consumes responses.
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Single-outstanding load/store sequencer in front of a registered-read data memory.
// Range-checks each request, drives the memory port and returns data or an error.
module dmem_access_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    dmem_access_ctrl_if.slave bus,
    output logic [ERR_W-1:0]  err_count,
    output logic              we_DM,
    output logic [ADDR_W-1:0] addDM,
    output logic [DATA_W-1:0] dataDM,
    input  logic [DATA_W-1:0] outDM
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

    state_t            state;
    logic              op_we;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op_we        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            err_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_we   <= bus.req_we;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        // Out-of-range requests never touch the memory port.
                        if (bus.req_addr >= LIMIT) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            err_count    <= sat_inc(err_count);
                            state        <= RESP;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (op_we) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        state        <= RESP;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= outDM;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The rst term keeps a reset arriving during a store from committing the write.
    assign we_DM          = (state == ACCESS) && op_we && !rst;
    assign addDM          = addr_q;
    assign dataDM         = wdata_q;
    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

endmodule
